// File: rtl/roi_static_monitor.sv
// -----------------------------------------------------------------------------
// roi_static_monitor
//
// Static-side harness for a partial-reconfiguration region.
//   * CHAN_N heartbeat outputs driven from one shared prescaler; channel i
//     toggles once every (i+1) prescaler wraps.
//   * Debounce/latch of the dynamic region's output bus: a new din value is
//     accepted only after STABLE_CYCLES consecutive identical samples.
//   * Saturating count of accepted changes, plus a one-cycle strobe per change.
//
// Optional feature (macro ROI_MON_TIMESTAMP_EN):
//   defined   -> 32-bit free-running cycle counter; last_change_ts captures its
//                value on every accept edge.
//   undefined -> no counter is built; last_change_ts is tied to 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   en             in   heartbeat enable (low freezes prescaler/dividers)
//   din            in   [DIN_N]  output bus of the dynamic region
//   blinky         out  [CHAN_N] registered heartbeat outputs
//   dout_latched   out  [DIN_N]  last accepted din value
//   change_pulse   out  one-cycle strobe, the cycle after each accept
//   change_cnt     out  [CNT_W]  accepted changes, saturating
//   stable         out  combinational din == dout_latched
//   last_change_ts out  [32]     cycle count at the last accept
// -----------------------------------------------------------------------------
module roi_static_monitor #(
    parameter int CHAN_N        = 3,
    parameter int PERIOD        = 10000000,
    parameter int DIN_N         = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DIN_N-1:0]  din,
    output logic [CHAN_N-1:0] blinky,
    output logic [DIN_N-1:0]  dout_latched,
    output logic              change_pulse,
    output logic [CNT_W-1:0]  change_cnt,
    output logic              stable,
    output logic [31:0]       last_change_ts
);

    localparam int PRE_W = $clog2(PERIOD);
    localparam int DIV_W = (CHAN_N > 1) ? $clog2(CHAN_N) : 1;
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PERIOD - 1);
    localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_CAND
    } mon_state_t;

    // -------------------------------------------------------------------------
    // Heartbeat: shared prescaler plus one divider per channel
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q;
    logic             tick_stb;
    logic [DIV_W-1:0] div_q [CHAN_N];

    // Gated by en so that a frozen prescaler sitting at PERIOD-1 does not keep
    // advancing the dividers.
    assign tick_stb = en && (pre_q == PRE_LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (en) begin
            if (tick_stb) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    // Divider i counts ticks 0..i; the tick that finds it at i toggles the
    // channel and restarts the count, giving a half-period of (i+1)*PERIOD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHAN_N; i++) begin
                div_q[i] <= '0;
            end
            blinky <= '0;
        end else if (tick_stb) begin
            for (int i = 0; i < CHAN_N; i++) begin
                if (div_q[i] == DIV_W'(i)) begin
                    div_q[i]  <= '0;
                    blinky[i] <= ~blinky[i];
                end else begin
                    div_q[i] <= div_q[i] + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor FSM: debounce din against dout_latched
    // -------------------------------------------------------------------------
    mon_state_t       state_q, state_d;
    logic [DIN_N-1:0] cand_q, cand_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_inc;
    logic             accept;
    logic [DIN_N-1:0] accept_val;

    assign run_inc = run_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        run_d      = run_q;
        accept     = 1'b0;
        accept_val = cand_q;

        unique case (state_q)
            ST_IDLE: begin
                if (din != dout_latched) begin
                    if (STABLE_CYCLES == 1) begin
                        // A single sample is already enough: accept directly.
                        accept     = 1'b1;
                        accept_val = din;
                    end else begin
                        state_d = ST_CAND;
                        cand_d  = din;
                        run_d   = RUN_ONE;
                    end
                end
            end

            ST_CAND: begin
                if (din == cand_q) begin
                    if (run_inc == RUN_DONE) begin
                        accept     = 1'b1;
                        accept_val = cand_q;
                        state_d    = ST_IDLE;
                        run_d      = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end else if (din == dout_latched) begin
                    // Glitch returned to the latched value: drop the candidate.
                    state_d = ST_IDLE;
                    run_d   = '0;
                end else begin
                    // A third value appeared: it becomes the new candidate.
                    cand_d = din;
                    run_d  = RUN_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q       <= '0;
            run_q        <= '0;
            dout_latched <= '0;
            change_pulse <= 1'b0;
            change_cnt   <= '0;
        end else begin
            cand_q       <= cand_d;
            run_q        <= run_d;
            change_pulse <= accept;
            if (accept) begin
                dout_latched <= accept_val;
                if (change_cnt != '1) begin
                    change_cnt <= change_cnt + 1'b1;
                end
            end
        end
    end

    assign stable = (din == dout_latched);

    // -------------------------------------------------------------------------
    // Optional accept timestamp
    // -------------------------------------------------------------------------
`ifdef ROI_MON_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q       <= '0;
            last_change_ts <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (accept) begin
                last_change_ts <= ts_cnt_q;
            end
        end
    end
`else
    assign last_change_ts = '0;
`endif

endmodule

// File: tb/tb_roi_static_monitor.sv
// -----------------------------------------------------------------------------
// tb_roi_static_monitor
//
// Bench for roi_static_monitor with PERIOD=4, CHAN_N=3, DIN_N=3,
// STABLE_CYCLES=3, CNT_W=2. Accepted changes are predicted into a queue when
// din is driven and checked when change_pulse appears; heartbeat outputs are
// compared against a closed-form count of enabled cycles.
// -----------------------------------------------------------------------------
module tb_roi_static_monitor;

    localparam int CHAN_N        = 3;
    localparam int PERIOD        = 4;
    localparam int DIN_N         = 3;
    localparam int STABLE_CYCLES = 3;
    localparam int CNT_W         = 2;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

`ifdef ROI_MON_TIMESTAMP_EN
    localparam logic [31:0] EXP_TS = 32'd20;
`else
    localparam logic [31:0] EXP_TS = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [DIN_N-1:0]  din = '0;
    logic [CHAN_N-1:0] blinky;
    logic [DIN_N-1:0]  dout_latched;
    logic              change_pulse;
    logic [CNT_W-1:0]  change_cnt;
    logic              stable;
    logic [31:0]       last_change_ts;

    roi_static_monitor #(
        .CHAN_N        (CHAN_N),
        .PERIOD        (PERIOD),
        .DIN_N         (DIN_N),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .din            (din),
        .blinky         (blinky),
        .dout_latched   (dout_latched),
        .change_pulse   (change_pulse),
        .change_cnt     (change_cnt),
        .stable         (stable),
        .last_change_ts (last_change_ts)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DIN_N-1:0] data;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_item;
    int   cnt_model = 0;
    int   en_cycles = 0;

    // Enabled clock edges since reset; heartbeat state is a pure function of it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cycles <= 0;
        end else if (en) begin
            en_cycles <= en_cycles + 1;
        end
    end

    function automatic logic [CHAN_N-1:0] hb_model(int n);
        logic [CHAN_N-1:0] r;
        for (int i = 0; i < CHAN_N; i++) begin
            r[i] = ((n / ((i + 1) * PERIOD)) % 2) == 1;
        end
        return r;
    endfunction

    // Scoreboard: every change_pulse must match the oldest predicted change.
    always @(negedge clk) begin
        if (rst_n && change_pulse) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_pulse: got dout_latched=%0d change_cnt=%0d, expected no change",
                         dout_latched, change_cnt);
            end else begin
                sb_item = sb_q.pop_front();
                if (dout_latched !== sb_item.data || change_cnt !== sb_item.cnt) begin
                    bad++;
                    $display("FAIL sb_change: got dout_latched=%0d change_cnt=%0d, expected %0d/%0d",
                             dout_latched, change_cnt, sb_item.data, sb_item.cnt);
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_change(logic [DIN_N-1:0] v);
        exp_t e;
        cnt_model++;
        e.data = v;
        e.cnt  = CNT_W'((cnt_model > CNT_MAX) ? CNT_MAX : cnt_model);
        sb_q.push_back(e);
    endtask

    // Hold reset for two edges, release between edges, clear the predictions.
    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        din   = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        sb_q.delete();
        cnt_model = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        din   = '0;
        #12;
        total++;
        if (blinky !== '0 || dout_latched !== '0 || change_pulse !== 1'b0 ||
            change_cnt !== '0 || stable !== 1'b1 || last_change_ts !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got blinky=%b dout=%0d pulse=%b cnt=%0d stable=%b ts=%0d, expected 0/0/0/0/1/0",
                     blinky, dout_latched, change_pulse, change_cnt, stable, last_change_ts);
        end
    endtask

    task automatic test_heartbeat();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step(1);
            @(negedge clk);
            total++;
            if (blinky !== hb_model(en_cycles)) begin
                bad++;
                $display("FAIL heartbeat c=%0d: got blinky=%b, expected %b", c, blinky, hb_model(en_cycles));
            end
        end
        total++;
        if (change_cnt !== '0 || stable !== 1'b1) begin
            bad++;
            $display("FAIL idle_monitor: got change_cnt=%0d stable=%b, expected 0/1", change_cnt, stable);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL heartbeat_sb_left: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    task automatic test_en_gating();
        logic [CHAN_N-1:0] frozen;
        do_reset();
        frozen = '0;
        for (int c = 0; c < 50; c++) begin
            en = !(c >= 6 && c < 16);
            step(1);
            @(negedge clk);
            if (c == 6) frozen = blinky;
            total++;
            if (blinky !== hb_model(en_cycles)) begin
                bad++;
                $display("FAIL en_gating c=%0d: got blinky=%b, expected %b", c, blinky, hb_model(en_cycles));
            end
            if (c > 6 && c < 16) begin
                total++;
                if (blinky !== frozen) begin
                    bad++;
                    $display("FAIL en_frozen c=%0d: got blinky=%b, expected %b", c, blinky, frozen);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_clean_change();
        do_reset();
        step(2);
        din = 3'd5;
        expect_change(3'd5);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            @(negedge clk);
            total++;
            if (dout_latched !== ((k >= 3) ? 3'd5 : 3'd0) || change_pulse !== (k == 3)) begin
                bad++;
                $display("FAIL clean_change k=%0d: got dout=%0d pulse=%b, expected %0d/%b",
                         k, dout_latched, change_pulse, (k >= 3) ? 5 : 0, k == 3);
            end
        end
        total++;
        if (change_cnt !== 2'd1 || stable !== 1'b1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL clean_change_end: got cnt=%0d stable=%b pending=%0d, expected 1/1/0",
                     change_cnt, stable, sb_q.size());
        end
    endtask

    task automatic test_glitch();
        do_reset();
        step(1);
        din = 3'd5;
        step(2);
        din = 3'd0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            @(negedge clk);
            total++;
            if (dout_latched !== 3'd0 || change_cnt !== '0 || change_pulse !== 1'b0) begin
                bad++;
                $display("FAIL glitch_reject k=%0d: got dout=%0d cnt=%0d pulse=%b, expected 0/0/0",
                         k, dout_latched, change_cnt, change_pulse);
            end
        end
        din = 3'd3;
        step(1);
        din = 3'd6;
        expect_change(3'd6);
        step(2);
        total++;
        if (dout_latched !== 3'd0) begin
            bad++;
            $display("FAIL glitch_restart_early: got dout=%0d, expected 0", dout_latched);
        end
        step(1);
        total++;
        if (dout_latched !== 3'd6) begin
            bad++;
            $display("FAIL glitch_restart_accept: got dout=%0d, expected 6", dout_latched);
        end
        step(2);
        total++;
        if (change_cnt !== 2'd1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL glitch_end: got cnt=%0d pending=%0d, expected 1/0", change_cnt, sb_q.size());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        step(1);
        for (int v = 1; v <= 5; v++) begin
            din = DIN_N'(v);
            expect_change(DIN_N'(v));
            step(4);
            total++;
            if (change_cnt !== CNT_W'((v > CNT_MAX) ? CNT_MAX : v)) begin
                bad++;
                $display("FAIL saturation v=%0d: got cnt=%0d, expected %0d",
                         v, change_cnt, (v > CNT_MAX) ? CNT_MAX : v);
            end
        end
        step(2);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL saturation_pulses: got %0d pulses missing, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_timestamp();
        do_reset();
        step(1);
        din = 3'd7;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (blinky !== '0 || dout_latched !== '0 || change_pulse !== 1'b0 ||
            change_cnt !== '0 || stable !== 1'b0 || last_change_ts !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: got blinky=%b dout=%0d pulse=%b cnt=%0d stable=%b ts=%0d, expected 0/0/0/0/0/0",
                     blinky, dout_latched, change_pulse, change_cnt, stable, last_change_ts);
        end
        do_reset();
        step(18);
        total++;
        if (dout_latched !== '0 || change_cnt !== '0) begin
            bad++;
            $display("FAIL cand_discarded: got dout=%0d cnt=%0d, expected 0/0", dout_latched, change_cnt);
        end
        din = 3'd7;
        expect_change(3'd7);
        step(3);
        total++;
        if (dout_latched !== 3'd7 || last_change_ts !== EXP_TS) begin
            bad++;
            $display("FAIL timestamp: got dout=%0d ts=%0d, expected 7/%0d", dout_latched, last_change_ts, EXP_TS);
        end
        step(3);
        total++;
        if (sb_q.size() != 0 || last_change_ts !== EXP_TS) begin
            bad++;
            $display("FAIL timestamp_end: got pending=%0d ts=%0d, expected 0/%0d", sb_q.size(), last_change_ts, EXP_TS);
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_en_gating();
        test_clean_change();
        test_glitch();
        test_saturation();
        test_reset_timestamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
